// File: rtl/store_buffer_unit_pkg.sv
// Shared definitions for the store buffer: MIPS store opcodes, entry layout
// and the ALU control codes used by the surrounding datapath.
package store_buffer_unit_pkg;

  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // An entry holds the word address (byte-offset bits dropped), the lane-aligned data and byte enables
  function automatic int entry_width(input int addr_w);
    return (addr_w - 2) + DATA_W + BE_W;
  endfunction

  localparam int ENTRY_W = entry_width(32);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_t;

endpackage

// File: rtl/store_buffer_unit_store_fifo.sv
// Circular FIFO holding pending stores; pointers wrap at DEPTH so any depth works.
module store_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && (count != '0) && !flush;
  assign head_data = storage[rd_ptr];

  // Data storage carries no reset; only occupied slots are ever observed
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue outright
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer_unit.sv
// Store buffer: decodes MIPS sb/sh/sw, aligns data into byte lanes and queues
// aligned stores for memory; bad requests are dropped with an error pulse.
module store_buffer_unit
  import store_buffer_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [31:0]                 instruction,
  input  logic [31:0]                 Read_data1,
  input  logic [31:0]                 Read_data2,
  input  logic                        flush,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [31:0]                 mem_wdata,
  output logic [3:0]                  mem_be,
  output logic                        misalign_err,
  output logic                        illegal_err,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int EW = entry_width(ADDR_W);

  logic [5:0]        opcode;
  logic [ADDR_W-1:0] ea;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              is_store;
  logic              misaligned;
  logic              accept;
  logic              push;
  logic              full;
  logic [EW-1:0]     head;
  logic              unused_fields;

  assign opcode        = instruction[31:26];
  assign ea            = ADDR_W'(Read_data1) + ADDR_W'($signed(instruction[15:0]));
  assign unused_fields = ^instruction[25:16];

  assign req_ready = !full && !flush;
  assign accept    = req_valid && req_ready;
  assign push      = accept && is_store && !misaligned;

  // Lane placement, byte enables and alignment check per store width
  always_comb begin
    be         = 4'b0000;
    wdata      = 32'h0;
    is_store   = 1'b1;
    misaligned = 1'b0;
    case (opcode)
      OP_SB: begin
        be    = 4'b0001 << ea[1:0];
        wdata = {4{Read_data2[7:0]}};
      end
      OP_SH: begin
        be         = ea[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{Read_data2[15:0]}};
        misaligned = ea[0];
      end
      OP_SW: begin
        be         = 4'b1111;
        wdata      = Read_data2;
        misaligned = (ea[1:0] != 2'b00);
      end
      default: is_store = 1'b0;
    endcase
  end

  // Error pulses land one cycle after the offending request is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_err <= 1'b0;
      illegal_err  <= 1'b0;
    end else begin
      misalign_err <= accept && is_store && misaligned;
      illegal_err  <= accept && !is_store;
    end
  end

  store_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data ({ea[ADDR_W-1:2], wdata, be}),
    .pop       (mem_ready),
    .head_data (head),
    .count     (count),
    .full      (full)
  );

  assign mem_valid = (count != '0);
  assign mem_addr  = {head[EW-1 -: ADDR_W-2], 2'b00};
  assign mem_wdata = head[35:4];
  assign mem_be    = head[3:0];

endmodule

// File: tb/tb_store_buffer_unit.sv
// Testbench for store_buffer_unit: queue-based reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_store_buffer_unit;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 5;
  localparam int CW     = $clog2(DEPTH+1);

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   instruction;
  logic [31:0]   Read_data1;
  logic [31:0]   Read_data2;
  logic          flush;
  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          misalign_err;
  logic          illegal_err;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  entry_t model_q[$];
  logic   exp_mis = 1'b0;
  logic   exp_ill = 1'b0;

  store_buffer_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .instruction  (instruction),
    .Read_data1   (Read_data1),
    .Read_data2   (Read_data2),
    .flush        (flush),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .misalign_err (misalign_err),
    .illegal_err  (illegal_err),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: what the buffer must hold after each edge, from the store rules
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q.delete();
      exp_mis = 1'b0;
      exp_ill = 1'b0;
    end else begin
      logic        acc;
      logic        ret;
      logic [31:0] ea;
      logic [5:0]  op;
      entry_t      e;
      acc = req_valid && (model_q.size() < DEPTH) && !flush;
      ret = (model_q.size() != 0) && mem_ready && !flush;
      exp_mis = 1'b0;
      exp_ill = 1'b0;
      if (flush) begin
        model_q.delete();
      end else begin
        if (ret) void'(model_q.pop_front());
        if (acc) begin
          op = instruction[31:26];
          ea = Read_data1 + {{16{instruction[15]}}, instruction[15:0]};
          e.addr = ea & 32'hFFFF_FFFC;
          if (op == 6'h28) begin
            e.be   = 4'(1 << (ea % 4));
            e.data = Read_data2[7:0] * 32'h0101_0101;
            model_q.push_back(e);
          end else if (op == 6'h29) begin
            if (ea % 2 != 0) exp_mis = 1'b1;
            else begin
              e.be   = (ea % 4 == 2) ? 4'b1100 : 4'b0011;
              e.data = Read_data2[15:0] * 32'h0001_0001;
              model_q.push_back(e);
            end
          end else if (op == 6'h2B) begin
            if (ea % 4 != 0) exp_mis = 1'b1;
            else begin
              e.be   = 4'b1111;
              e.data = Read_data2;
              model_q.push_back(e);
            end
          end else begin
            exp_ill = 1'b1;
          end
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    check_output("count", 64'(count), 64'(model_q.size()));
    check_output("mem_valid", 64'(mem_valid), 64'(model_q.size() != 0));
    check_output("req_ready", 64'(req_ready), 64'((model_q.size() < DEPTH) && !flush));
    check_output("misalign_err", 64'(misalign_err), 64'(exp_mis));
    check_output("illegal_err", 64'(illegal_err), 64'(exp_ill));
    if (model_q.size() != 0) begin
      check_output("mem_addr", 64'(mem_addr), 64'(model_q[0].addr));
      check_output("mem_wdata", 64'(mem_wdata), 64'(model_q[0].data));
      check_output("mem_be", 64'(mem_be), 64'(model_q[0].be));
    end
  end

  task automatic apply_stimulus(input logic [5:0] op, input logic [31:0] base,
                                input logic [15:0] off, input logic [31:0] rt);
    instruction = {op, 5'd1, 5'd2, off};
    Read_data1  = base;
    Read_data2  = rt;
    req_valid   = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic retire_one();
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
  endtask

  initial begin
    int budget;
    reset       = 1'b1;
    req_valid   = 1'b0;
    instruction = 32'h0;
    Read_data1  = 32'h0;
    Read_data2  = 32'h0;
    flush       = 1'b0;
    mem_ready   = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_output("reset_count", 64'(count), 64'd0);
    check_output("reset_mem_valid", 64'(mem_valid), 64'd0);
    check_output("reset_misalign", 64'(misalign_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_output("ready_after_reset", 64'(req_ready), 64'd1);

    // sw with negative offset
    apply_stimulus(6'h2B, 32'h1000, 16'hFFFC, 32'hDEADBEEF);
    check_output("s1_addr", 64'(mem_addr), 64'h0FFC);
    check_output("s1_be", 64'(mem_be), 64'hF);
    check_output("s1_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    check_output("s1_count", 64'(count), 64'd1);
    retire_one();

    // sb into the top lane
    apply_stimulus(6'h28, 32'h2003, 16'h0000, 32'h000000A5);
    check_output("s2_addr", 64'(mem_addr), 64'h2000);
    check_output("s2_be", 64'(mem_be), 64'h8);
    check_output("s2_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
    retire_one();

    // misaligned sh
    apply_stimulus(6'h29, 32'h3000, 16'h0001, 32'h1234);
    check_output("s3_misalign", 64'(misalign_err), 64'd1);
    check_output("s3_count", 64'(count), 64'd0);
    check_output("s3_mem_valid", 64'(mem_valid), 64'd0);
    @(posedge clk); #1;
    check_output("s3_pulse_end", 64'(misalign_err), 64'd0);

    // non-store opcode (lw)
    apply_stimulus(6'h23, 32'h4000, 16'h0000, 32'h0);
    check_output("illegal_pulse", 64'(illegal_err), 64'd1);
    check_output("illegal_count", 64'(count), 64'd0);

    // back-to-back stores with memory always ready
    mem_ready = 1'b1;
    apply_stimulus(6'h29, 32'h4000, 16'h0002, 32'hCAFE_BABE);
    check_output("sh_upper_be", 64'(mem_be), 64'hC);
    check_output("sh_upper_data", 64'(mem_wdata), 64'hBABEBABE);
    apply_stimulus(6'h28, 32'h4000, 16'h0001, 32'h0000_0077);
    check_output("stream_count", 64'(count), 64'd1);
    apply_stimulus(6'h29, 32'h4100, 16'h0000, 32'h0000_1122);
    apply_stimulus(6'h2B, 32'h4200, 16'h0010, 32'h5555_AAAA);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check_output("stream_drained", 64'(count), 64'd0);

    // fill past capacity, then a full cycle with retire but no acceptance
    for (int i = 0; i <= DEPTH; i++)
      apply_stimulus(6'h2B, 32'h5000 + 32'(4 * i), 16'h0000, 32'(i + 1));
    check_output("s4_full_count", 64'(count), 64'(DEPTH));
    check_output("s4_ready_low", 64'(req_ready), 64'd0);
    check_output("s4_head", 64'(mem_addr), 64'h5000);
    instruction = {6'h2B, 10'd0, 16'h0000};
    Read_data1  = 32'h6000;
    req_valid   = 1'b1;
    mem_ready   = 1'b1;
    #1;
    check_output("s4_ready_full_retire", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_output("s4_after_retire", 64'(count), 64'(DEPTH - 1));
    check_output("s4_next_head", 64'(mem_addr), 64'h5004);
    budget = 0;
    while (count != 0 && budget < 40) begin
      @(posedge clk); #1;
      budget++;
    end
    check_output("s4_drain_done", 64'(count), 64'd0);
    check_output("s4_drain_cycles", 64'(budget), 64'(DEPTH - 1));
    mem_ready = 1'b0;

    // flush together with a request
    apply_stimulus(6'h2B, 32'h7000, 16'h0000, 32'h1);
    apply_stimulus(6'h2B, 32'h7004, 16'h0000, 32'h2);
    apply_stimulus(6'h2B, 32'h7008, 16'h0000, 32'h3);
    check_output("s5_count_before", 64'(count), 64'd3);
    instruction = {6'h2B, 10'd0, 16'h0000};
    Read_data1  = 32'h700C;
    req_valid   = 1'b1;
    flush       = 1'b1;
    #1;
    check_output("s5_ready_during_flush", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    check_output("s5_count_after", 64'(count), 64'd0);
    check_output("s5_mem_valid_after", 64'(mem_valid), 64'd0);

    // asynchronous reset with two entries queued
    apply_stimulus(6'h2B, 32'h8000, 16'h0000, 32'hA);
    apply_stimulus(6'h2B, 32'h8004, 16'h0000, 32'hB);
    check_output("s6_count_before", 64'(count), 64'd2);
    mem_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    check_output("s6_count_async", 64'(count), 64'd0);
    check_output("s6_mem_valid_async", 64'(mem_valid), 64'd0);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // recovery after reset
    apply_stimulus(6'h28, 32'h9000, 16'h0002, 32'h0000_003C);
    check_output("recover_be", 64'(mem_be), 64'h4);
    check_output("recover_data", 64'(mem_wdata), 64'h3C3C3C3C);
    retire_one();
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer_unit.md
STORE_BUFFER_UNIT -- requirements
Module: store_buffer_unit

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width; the low ADDR_W bits of the computed address are used.
REQ-002 Parameter DEPTH, default 4: store-buffer entries; legal range 2..16, need not be a power of two.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  a store instruction and its operands are presented.
REQ-006 req_ready  output  1  the unit accepts a request this cycle.
REQ-007 instruction  input  32  MIPS I-type word: opcode [31:26], offset [15:0].
REQ-008 Read_data1  input  32  base register value (rs).
REQ-009 Read_data2  input  32  store data register value (rt).
REQ-010 flush  input  1  synchronous discard of all buffered stores.
REQ-011 mem_valid  output  1  the head entry is presented to memory.
REQ-012 mem_ready  input  1  memory accepts the head entry.
REQ-013 mem_addr  output  ADDR_W  word-aligned address; bits [1:0] are always 0.
REQ-014 mem_wdata  output  32  lane-aligned write data.
REQ-015 mem_be  output  4  byte enables; bit i enables byte lane i (little-endian).
REQ-016 misalign_err  output  1  one-cycle pulse when an accepted store is misaligned.
REQ-017 illegal_err  output  1  one-cycle pulse when an accepted opcode is not a store.
REQ-018 count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-019 A request is accepted when req_valid && req_ready; req_ready = !full && !flush.
REQ-020 ea = Read_data1 + sign-extended offset, modulo 2^ADDR_W; mem_addr = {ea[ADDR_W-1:2], 2'b00}.
REQ-021 Opcode 0x28 (sb): be = 1<<ea[1:0]; wdata = rt[7:0] replicated into all four lanes.
REQ-022 Opcode 0x29 (sh): be = 4'b0011 or 4'b1100 by ea[1]; wdata = rt[15:0] replicated into both halves; ea[0]=1 is misaligned.
REQ-023 Opcode 0x2B (sw): be = 4'b1111; wdata = rt; ea[1:0]!=0 is misaligned.
REQ-024 A misaligned or illegal request is accepted but not enqueued; the corresponding error output pulses high in the cycle after acceptance.
REQ-025 Aligned stores are enqueued in FIFO order; an entry is visible on mem_valid no earlier than the cycle after acceptance (no bypass).
REQ-026 mem_valid = (count != 0); mem_addr, mem_wdata and mem_be come from the head entry.
REQ-027 The head entry is retired on mem_valid && mem_ready; while mem_valid && !mem_ready the outputs remain stable.
REQ-028 Simultaneous enqueue and retire leave count unchanged; when full, req_ready is low even if a retire occurs that cycle.
REQ-029 Read and write pointers wrap from DEPTH-1 to 0.
REQ-030 When flush is high at a clock edge: count becomes 0, both pointers become 0, any concurrent request is not accepted, and no retire is counted.

Reset
REQ-031 On reset low, asynchronously: count=0, pointers=0, mem_valid=0, misalign_err=0, illegal_err=0; req_ready=1 once reset is released.
REQ-032 Buffer data storage is not reset; mem_addr, mem_wdata and mem_be are don't-care while mem_valid=0.
REQ-033 Reset asserted mid-operation discards all entries; a memory handshake in progress is abandoned.

Structure
REQ-034 Opcode constants (OP_SB, OP_SH, OP_SW) and the entry width belong in the shared package, alongside the ALU control codes.
REQ-035 The FIFO is a sub-module, store_fifo, parametrised by DEPTH and entry width; the align/byte-enable logic stays in the top level.

Verification
REQ-036 Scenario 1: sw with base=0x1000, offset=0xFFFC, rt=0xDEADBEEF -> mem_addr=0x0FFC, be=1111, wdata=0xDEADBEEF.
REQ-037 Scenario 2: sb with base=0x2003, offset=0, rt=0x000000A5 -> mem_addr=0x2000, be=1000, wdata=0xA5A5A5A5.
REQ-038 Scenario 3: sh to ea=0x3001 -> misalign_err pulses one cycle, count unchanged, mem_valid stays 0.
REQ-039 Scenario 4: mem_ready held 0, DEPTH+1 stores issued -> req_ready falls after DEPTH entries; releasing mem_ready drains them in order; at most one retire per cycle.
REQ-040 Scenario 5: three entries queued, flush asserted together with req_valid -> next cycle count=0, mem_valid=0, and the request is not accepted.
REQ-041 Scenario 6: reset pulsed low between clock edges while count=2 -> count=0 and mem_valid=0 immediately, without waiting for a clock edge.
